// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & INSTR_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; element type is a parameter so the same
// block buffers fetched entries and tracks in-flight request addresses.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  T                             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output T                             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en, pop_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    pop_en   = pop && (count_q != '0);
    // a full FIFO can still accept when the head leaves in the same cycle
    push_en  = push && ((count_q != FULL) || pop_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_en) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_en && !pop_en)      count_d = count_q + CNT_W'(1);
      else if (!push_en && pop_en) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited imem requests, in-order response
// buffering, redirect flush/drain. Define FETCH_PERF_EN for perf counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] fifo_count, pcq_count, outstanding;
  fetch_entry_t    fifo_head, fifo_push_entry;
  logic [XLEN-1:0] pcq_head;
  logic            redirect_en, rsp_en, req_fire, fifo_push, fifo_pop, credit_ok;

  always_comb begin
    redirect_en     = redirect_valid && (state_q != BOOT);
    // in-flight requests are either still tracked by address or marked stale
    outstanding     = pcq_count + discard_q;
    rsp_en          = imem_rsp_valid && (outstanding != '0);
    credit_ok       = ({1'b0, outstanding} + {1'b0, fifo_count}) < SUM_W'(FIFO_DEPTH);
    imem_req_valid  = (state_q == FETCH) && credit_ok && !redirect_valid;
    req_fire        = imem_req_valid && imem_req_ready;
    fifo_push       = (state_q == FETCH) && rsp_en && !redirect_en;
    fifo_pop        = instr_valid && instr_ready && !redirect_en;
    fifo_push_entry = '{pc: pcq_head, instr: imem_rsp_data};

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH, DRAIN: begin
        if (redirect_en) begin
          fetch_pc_d = align_pc(redirect_pc);
          discard_d  = outstanding - CNT_W'(rsp_en);
          state_d    = (discard_d != '0) ? DRAIN : FETCH;
        end else if (state_q == FETCH) begin
          if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
        end else if (rsp_en) begin
          discard_d = discard_q - CNT_W'(1);
          if (discard_d == '0) state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_entry_t)) u_instr_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (fifo_push),
    .push_data (fifo_push_entry),
    .pop       (fifo_pop),
    .flush     (redirect_en),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // addresses of live requests, popped as their responses are buffered
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(logic [XLEN-1:0])) u_pc_queue (
    .clk       (clk),
    .rst_n     (reset),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (fifo_push),
    .flush     (redirect_en),
    .head      (pcq_head),
    .count     (pcq_count)
  );

  assign imem_req_addr = fetch_pc_q;
  assign instr_valid   = (fifo_count != '0);
  assign instr_data    = instr_valid ? fifo_head.instr : '0;
  assign instr_pc      = instr_valid ? fifo_head.pc : '0;

  rsp_has_owner: assert property (@(posedge clk) disable iff (!reset)
    imem_rsp_valid |-> (outstanding != '0));

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(fifo_pop);
    perf_flushed_d = perf_flushed_q;
    if (redirect_en)
      perf_flushed_d = perf_flushed_q + 32'(fifo_count) + 32'(rsp_en);
    else if ((state_q == DRAIN) && rsp_en)
      perf_flushed_d = perf_flushed_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the single-cycle core's instruction register and decoder. Issues word-aligned fetch requests to a variable-latency instruction memory over a valid/ready request channel and an in-order response channel. Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake. Handles PC redirects (jumps/branches) by flushing the buffer and discarding stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset; low 2 bits must be 0.
FIFO_DEPTH, 2, instruction buffer entries; also the credit limit (outstanding + buffered <= FIFO_DEPTH); power of two, >= 1.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word-aligned fetch address
imem_rsp_valid  input  1  response valid (one per accepted request, in order, >= 1 cycle after accept)
imem_rsp_data  input  32  instruction word
redirect_valid  input  1  PC redirect strobe from core
redirect_pc  input  32  new fetch target
instr_valid  output  1  buffered instruction available
instr_ready  input  1  decode consumes instruction
instr_data  output  32  instruction word at FIFO head
instr_pc  output  32  PC of instr_data

Behaviour:
- Reset (reset=0, async): fetch_pc=RESET_PC, state=BOOT, FIFO empty, outstanding=0, discard=0; imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0.
- States: BOOT -> FETCH unconditionally after first clock with reset=1. FETCH: issue requests. DRAIN: discard stale responses, no requests.
- FETCH: imem_req_valid=1 iff (outstanding + fifo_count) < FIFO_DEPTH. Handshake = valid & ready: outstanding++, fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0). While valid & !ready, addr and valid stay stable.
- Response in FETCH: push {data, pc} into FIFO, outstanding--; PC per entry is tracked in a parallel in-order queue of issued addresses.
- Output: instr_valid = FIFO non-empty; pop on instr_valid & instr_ready. Push to empty FIFO -> instr_valid in next cycle (registered). Earliest path: req accepted cycle N, rsp cycle N+1, instr_valid N+2.
- Simultaneous push and pop: both occur, count unchanged. Overflow impossible by credit; response with outstanding=0 is a protocol error (asserted in simulation, ignored in RTL).
- Redirect (highest priority, any state except BOOT): fetch_pc <= {redirect_pc[31:2],2'b00}; FIFO flushed (same-cycle pop is void); same-cycle response dropped; discard <= outstanding after this cycle's events (a request handshaking this cycle counts). Next state DRAIN if discard>0, else FETCH. imem_req_valid forced 0 in redirect cycle.
- DRAIN: each response decrements discard and outstanding, is not pushed; discard reaching 0 -> FETCH next cycle. Redirect in DRAIN updates fetch_pc, stays/recomputes.
- Redirect in BOOT ignored.
- Reset asserted mid-operation: immediate return to reset values; memory responses after reset release to pre-reset requests are the memory's responsibility (memory must share reset).

Optional Feature:
FETCH_PERF_EN: when defined, adds outputs perf_fetched (32, count of instructions popped to decode) and perf_flushed (32, count of FIFO entries plus responses discarded by redirects), both reset to 0, wrap at 2^32. When undefined, ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package fetch_pkg: fetch_state_e {BOOT, FETCH, DRAIN}; XLEN=32; INSTR_ALIGN_MASK=32'hFFFF_FFFC; fetch_entry_t struct {pc, instr}.
- One sub-module: fetch_fifo (parameterised depth, push/pop/flush, count output, storing fetch_entry_t).

Test Plan:
- Reset then imem_req_ready=1, 1-cycle memory, instr_ready=1 -> addrs 0x0,0x4,0x8...; first instr_valid 2 cycles after first accept; instr_pc tracks addresses.
- instr_ready=0 for 10 cycles -> exactly 2 requests accepted, imem_req_valid drops, FIFO holds PCs 0x0/0x4; release -> in-order drain, fetching resumes at 0x8.
- imem_req_ready=0 for 3 cycles -> imem_req_addr stable at 0x0, no duplicate fetch.
- 2 requests in flight (3-cycle memory), redirect_pc=0x100 -> DRAIN, both responses dropped, next request addr 0x100, first delivered instr_pc=0x100.
- redirect_pc=0x203 while FIFO full -> instr_valid 0 next cycle, next fetch 0x200.
- fetch_pc=0xFFFF_FFFC accepted -> next request addr 0x0000_0000.
